// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, ALU op
// classes, datapath select codes and the RV32I opcodes shared with the ALU
// decoder.
package multicycle_control_fsm_pkg;

  localparam int unsigned STATE_BITS = 4;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_AUIPC    = 4'd9,
    S_ALUWB    = 4'd10,
    S_BRANCH   = 4'd11,
    S_JALRADR  = 4'd12,
    S_JAL      = 4'd13,
    S_HALT     = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format follows the opcode alone; I-format covers everything else.
  function automatic logic [2:0] imm_src_of(input logic [6:0] opc);
    case (opc)
      OPC_STORE:           imm_src_of = IMM_S;
      OPC_BRANCH:          imm_src_of = IMM_B;
      OPC_JAL:             imm_src_of = IMM_J;
      OPC_LUI, OPC_AUIPC:  imm_src_of = IMM_U;
      default:             imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_branch_cond.sv
// Branch resolution: funct3 selects which ALU compare flag decides "taken".
module branch_cond
  import multicycle_control_fsm_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       taken
);

  // funct3 010/011 are not branch encodings and never redirect the PC
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = ~alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = ~alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = ~alu_ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky
// TRAP state (illegal_instr=1, halted=1) instead of being skipped as NOPs.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int EBREAK_HALT = 1,
  parameter int STATE_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       halted,
  output logic       illegal_instr
);

  logic [STATE_W-1:0] state_q;
  state_t             state, state_d;
  logic               taken;
  logic               req_c, mwr_c, irw_c, pcw_c, rgw_c;

  assign state = state_t'(state_q[STATE_BITS-1:0]);

  branch_cond u_branch_cond (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_ltu  (alu_ltu),
    .taken    (taken)
  );

  // State register; reset drops any outstanding memory request
  always_ff @(posedge clk) begin
    if (rst) state_q <= STATE_W'(S_FETCH);
    else     state_q <= STATE_W'(state_d);
  end

  // Next-state and Moore datapath controls
  always_comb begin
    state_d    = state;
    req_c      = 1'b0;
    mwr_c      = 1'b0;
    irw_c      = 1'b0;
    pcw_c      = 1'b0;
    rgw_c      = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        req_c      = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        irw_c      = mem_ready;
        pcw_c      = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // precompute branch/JAL target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_OP:              state_d = S_EXECR;
          OPC_OP_IMM:          state_d = S_EXECI;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALRADR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          OPC_SYSTEM:          state_d = (EBREAK_HALT != 0) ? S_HALT : S_FETCH;
`ifdef ILLEGAL_TRAP_EN
          default:             state_d = S_TRAP;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        rgw_c      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c   = 1'b1;
        mwr_c   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rgw_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // PC loads the target held in ALUOut only when the compare says so
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pcw_c     = taken;
        state_d   = S_FETCH;
      end
      S_JALRADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = S_JAL;
      end
      S_JAL: begin
        // PC <= ALUOut (target), ALU computes old_pc+4 for the link write
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pcw_c     = 1'b1;
        state_d   = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held regardless of current state
  assign mem_req   = req_c & ~rst;
  assign mem_write = mwr_c & ~rst;
  assign ir_write  = irw_c & ~rst;
  assign pc_write  = pcw_c & ~rst;
  assign reg_write = rgw_c & ~rst;
  assign imm_src   = imm_src_of(opcode);
  assign halted    = ((state == S_HALT) || (state == S_TRAP)) & ~rst;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_TRAP) & ~rst;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle expected control
// vectors are queued as stimulus is planned and compared as the FSM runs.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       halted, illegal_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
    .halted(halted), .illegal_instr(illegal_instr)
  );

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011,
                         OPI = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         SYS = 7'b1110011;

  typedef enum {L_FETCH, L_DECODE, L_MEMADR, L_MEMREAD, L_MEMWB, L_MEMWRITE,
                L_EXECR, L_EXECI, L_LUI, L_AUIPC, L_ALUWB, L_BRANCH,
                L_JALRADR, L_JAL, L_HALT, L_TRAP} lab_t;

  typedef struct packed {
    logic req, mw, adr, ir, pc, rw;
    logic [1:0] a, b, op, rs;
    logic [2:0] imm;
    logic halt, ill;
  } ov_t;

  typedef struct {
    ov_t  v;
    ov_t  m;
    logic rdy;
    lab_t lab;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  ov_t  act;

  function automatic logic [2:0] imm_exp(input logic [6:0] opc);
    if (opc == STORE)                    return 3'b001;
    if (opc == BR)                       return 3'b010;
    if (opc == JAL)                      return 3'b011;
    if (opc == LUI || opc == AUIPC)      return 3'b100;
    return 3'b000;
  endfunction

  function automatic ov_t observe();
    ov_t o;
    o = '{req:mem_req, mw:mem_write, adr:adr_src, ir:ir_write, pc:pc_write,
          rw:reg_write, a:alu_src_a, b:alu_src_b, op:alu_op, rs:result_src,
          imm:imm_src, halt:halted, ill:illegal_instr};
    return o;
  endfunction

  // Plan one cycle: expected controls for a state plus the mem_ready to drive
  task automatic push(input lab_t l, input logic rdy, input logic tk);
    ent_t n;
    n.v = '0; n.m = '0;
    n.m.req = 1; n.m.mw = 1; n.m.ir = 1; n.m.pc = 1; n.m.rw = 1;
    n.m.imm = '1; n.m.halt = 1; n.m.ill = 1;
    n.v.imm = imm_exp(opcode);
    case (l)
      L_FETCH:    begin n.v.req = 1; n.v.ir = rdy; n.v.pc = rdy; n.v.b = 2'b10; n.v.rs = 2'b10;
                        n.m.adr = 1; n.m.a = '1; n.m.b = '1; n.m.op = '1; n.m.rs = '1; end
      L_DECODE:   begin n.v.a = 2'b01; n.v.b = 2'b01; n.m.a = '1; n.m.b = '1; n.m.op = '1; end
      L_MEMADR:   begin n.v.a = 2'b10; n.v.b = 2'b01; n.m.a = '1; n.m.b = '1; n.m.op = '1; end
      L_MEMREAD:  begin n.v.req = 1; n.v.adr = 1; n.m.adr = 1; end
      L_MEMWB:    begin n.v.rw = 1; n.v.rs = 2'b01; n.m.rs = '1; end
      L_MEMWRITE: begin n.v.req = 1; n.v.mw = 1; n.v.adr = 1; n.m.adr = 1; end
      L_EXECR:    begin n.v.a = 2'b10; n.v.op = 2'b10; n.m.a = '1; n.m.b = '1; n.m.op = '1; end
      L_EXECI:    begin n.v.a = 2'b10; n.v.b = 2'b01; n.v.op = 2'b10; n.m.a = '1; n.m.b = '1; n.m.op = '1; end
      L_LUI:      begin n.v.b = 2'b01; n.v.op = 2'b10; n.m.b = '1; n.m.op = '1; end
      L_AUIPC:    begin n.v.a = 2'b01; n.v.b = 2'b01; n.v.op = 2'b10; n.m.a = '1; n.m.b = '1; n.m.op = '1; end
      L_ALUWB:    begin n.v.rw = 1; n.m.rs = '1; end
      L_BRANCH:   begin n.v.pc = tk; n.v.a = 2'b10; n.v.op = 2'b01;
                        n.m.a = '1; n.m.b = '1; n.m.op = '1; n.m.rs = '1; end
      L_JALRADR:  begin n.v.a = 2'b10; n.v.b = 2'b01; n.m.a = '1; n.m.b = '1; n.m.op = '1; end
      L_JAL:      begin n.v.pc = 1; n.v.a = 2'b01; n.v.b = 2'b10;
                        n.m.a = '1; n.m.b = '1; n.m.op = '1; n.m.rs = '1; end
      L_HALT:     n.v.halt = 1;
      L_TRAP:     begin n.v.halt = 1; n.v.ill = 1; end
      default:    ;
    endcase
    n.rdy = rdy; n.lab = l;
    sb.push_back(n);
  endtask

  // Reset for one edge; returns on the negedge where cycle 1 (FETCH) starts
  task automatic apply_reset(input logic [6:0] opc, input logic [2:0] f3);
    @(negedge clk);
    rst = 1; mem_ready = 0; opcode = opc; funct3 = f3;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; mem_ready = 1; opcode = OP;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_req, mem_write, ir_write, pc_write, reg_write} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000",
                         {mem_req, mem_write, ir_write, pc_write, reg_write});
    end
    checks++;
    if ({halted, illegal_instr} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b want 00", {halted, illegal_instr});
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({mem_req, adr_src, ir_write, pc_write} !== 4'b1011) begin
      errors++; $display("FAIL reset_fetch: got %b want 1011", {mem_req, adr_src, ir_write, pc_write});
    end
    mem_ready = 0;
  endtask

  task automatic test_add();
    apply_reset(OP, 3'b000);
    push(L_FETCH, 1, 0); push(L_DECODE, 1, 0); push(L_EXECR, 1, 0);
    push(L_ALUWB, 1, 0); push(L_FETCH, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; #1;
      act = observe(); checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL add %s: got %h want %h mask %h", e.lab.name(), act, e.v, e.m);
      end
      @(negedge clk);
    end
  endtask

  // Load with two wait cycles in both FETCH and MEMREAD; mem_ready held high
  // outside requests to show it is ignored. MEMWB lands on cycle 9.
  task automatic test_lw();
    apply_reset(LOAD, 3'b010);
    push(L_FETCH, 0, 0); push(L_FETCH, 0, 0); push(L_FETCH, 1, 0);
    push(L_DECODE, 1, 0); push(L_MEMADR, 1, 0);
    push(L_MEMREAD, 0, 0); push(L_MEMREAD, 0, 0); push(L_MEMREAD, 1, 0);
    push(L_MEMWB, 1, 0); push(L_FETCH, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; #1;
      act = observe(); checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL lw %s: got %h want %h mask %h", e.lab.name(), act, e.v, e.m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b110, 3'b111, 3'b010};
    logic [2:0] flg [8] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b010, 3'b001, 3'b001, 3'b111};
    logic       tks [8] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
    for (int i = 0; i < 8; i++) begin
      apply_reset(BR, f3s[i]);
      {alu_zero, alu_lt, alu_ltu} = flg[i];
      push(L_FETCH, 1, 0); push(L_DECODE, 0, 0); push(L_BRANCH, 1, tks[i]); push(L_FETCH, 0, 0);
      while (sb.size() > 0) begin
        e = sb.pop_front(); mem_ready = e.rdy; #1;
        act = observe(); checks++;
        if ((act & e.m) !== (e.v & e.m)) begin
          errors++; $display("FAIL branch%0d %s: got %h want %h mask %h", i, e.lab.name(), act, e.v, e.m);
        end
        @(negedge clk);
      end
    end
    {alu_zero, alu_lt, alu_ltu} = 3'b000;
  endtask

  task automatic test_jump_misc();
    logic [6:0] opcs [6] = '{JALR, JAL, OPI, LUI, AUIPC, STORE};
    for (int i = 0; i < 6; i++) begin
      apply_reset(opcs[i], 3'b000);
      push(L_FETCH, 1, 0); push(L_DECODE, 1, 0);
      case (i)
        0: begin push(L_JALRADR, 1, 0); push(L_JAL, 1, 0); push(L_ALUWB, 1, 0); end
        1: begin push(L_JAL, 1, 0); push(L_ALUWB, 1, 0); end
        2: begin push(L_EXECI, 1, 0); push(L_ALUWB, 1, 0); end
        3: begin push(L_LUI, 1, 0); push(L_ALUWB, 1, 0); end
        4: begin push(L_AUIPC, 1, 0); push(L_ALUWB, 1, 0); end
        default: begin push(L_MEMADR, 1, 0); push(L_MEMWRITE, 1, 0); end
      endcase
      push(L_FETCH, 0, 0);
      while (sb.size() > 0) begin
        e = sb.pop_front(); mem_ready = e.rdy; #1;
        act = observe(); checks++;
        if ((act & e.m) !== (e.v & e.m)) begin
          errors++; $display("FAIL misc%0d %s: got %h want %h mask %h", i, e.lab.name(), act, e.v, e.m);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal();
    apply_reset(7'b0000000, 3'b000);
    push(L_FETCH, 1, 0); push(L_DECODE, 1, 0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) push(L_TRAP, 1, 0);
`else
    push(L_FETCH, 0, 0); push(L_FETCH, 0, 0);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; #1;
      act = observe(); checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL illegal %s: got %h want %h mask %h", e.lab.name(), act, e.v, e.m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid_write();
    apply_reset(STORE, 3'b010);
    push(L_FETCH, 1, 0); push(L_DECODE, 0, 0); push(L_MEMADR, 0, 0);
    push(L_MEMWRITE, 0, 0); push(L_MEMWRITE, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; #1;
      act = observe(); checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL rstwr %s: got %h want %h mask %h", e.lab.name(), act, e.v, e.m);
      end
      @(negedge clk);
    end
    rst = 1; #1;
    checks++;
    if ({mem_req, mem_write} !== 2'b00) begin
      errors++; $display("FAIL rstwr_hold: got %b want 00", {mem_req, mem_write});
    end
    @(negedge clk);
    rst = 0;
    push(L_FETCH, 0, 0); push(L_FETCH, 1, 0); push(L_DECODE, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; #1;
      act = observe(); checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL rstwr_after %s: got %h want %h mask %h", e.lab.name(), act, e.v, e.m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ebreak();
    apply_reset(SYS, 3'b000);
    push(L_FETCH, 1, 0); push(L_DECODE, 1, 0);
    for (int i = 0; i < 6; i++) push(L_HALT, 1, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); mem_ready = e.rdy; #1;
      act = observe(); checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++; $display("FAIL ebreak %s: got %h want %h mask %h", e.lab.name(), act, e.v, e.m);
      end
      @(negedge clk);
    end
    apply_reset(OP, 3'b000);
    #1;
    checks++;
    if ({halted, mem_req} !== 2'b01) begin
      errors++; $display("FAIL ebreak_release: got %b want 01", {halted, mem_req});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jump_misc();
    test_illegal();
    test_rst_mid_write();
    test_ebreak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
